t03_pad_poll_engine: RTL and testbench

//  Parametrised serial game-pad poller: successor to the fixed NES latch/pulse divider.

---
 rtl/t03_pad_pkg.sv | 19 +
 rtl/t03_pad_tick_gen.sv | 27 ++
 rtl/t03_pad_poll_engine.sv | 153 +++++++++++++++
 tb/tb_t03_pad_poll_engine.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_pad_pkg.sv
// Shared types and default constants for the serial game-pad poller.
package t03_pad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StShift,
        StDone,
        StWait
    } pad_state_e;

    localparam int unsigned NesBits       = 8;
    localparam int unsigned SnesBits      = 16;
    localparam int unsigned DefDiv        = 4;
    localparam int unsigned DefLatchTicks = 30;
    localparam int unsigned DefBitTicks   = 30;
    localparam int unsigned DefFrameTicks = 41668;

endpackage

// File: rtl/t03_pad_tick_gen.sv
// Free-running prescaler: one-clock tick every DIV clocks.
module t03_pad_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);

    localparam int unsigned DW = $clog2(DIV + 1);
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_cnt <= '0;
        end else if (div_cnt == DivLast) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == DivLast);

endmodule

// File: rtl/t03_pad_poll_engine.sv
// Multi-pad serial game-pad poller with one-shot and auto modes.
// Define T03_PAD_DEBOUNCE_EN to publish a bit only after two matching frames.
module t03_pad_poll_engine
    import t03_pad_pkg::*;
#(
    parameter int unsigned N_PADS      = 2,
    parameter int unsigned N_BITS      = NesBits,
    parameter int unsigned DIV         = DefDiv,
    parameter int unsigned LATCH_TICKS = DefLatchTicks,
    parameter int unsigned BIT_TICKS   = DefBitTicks,
    parameter int unsigned FRAME_TICKS = DefFrameTicks
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     start_i,
    input  logic                     auto_i,
    input  logic [N_PADS-1:0]        pad_data_i,
    output logic                     pad_latch_o,
    output logic                     pad_clk_o,
    output logic [N_PADS*N_BITS-1:0] buttons_o,
    output logic                     frame_valid_o,
    output logic                     busy_o
);

    localparam int unsigned LW = $clog2(LATCH_TICKS + 1);
    localparam int unsigned PW = $clog2(BIT_TICKS + 1);
    localparam int unsigned BW = $clog2(N_BITS + 1);
    localparam int unsigned FW = $clog2(FRAME_TICKS + 1);

    localparam logic [LW-1:0] LatchLast = LW'(LATCH_TICKS - 1);
    localparam logic [PW-1:0] PhaseLast = PW'(BIT_TICKS - 1);
    localparam logic [PW-1:0] PhaseHalf = PW'(BIT_TICKS / 2);
    localparam logic [BW-1:0] BitLast   = BW'(N_BITS - 1);
    localparam logic [FW-1:0] FrameLast = FW'(FRAME_TICKS - 1);
    localparam logic [FW-1:0] FrameMax  = FW'(FRAME_TICKS);

    pad_state_e                       state;
    logic                             tick;
    logic [LW-1:0]                    latch_cnt;
    logic [PW-1:0]                    phase_cnt;
    logic [BW-1:0]                    bit_cnt;
    logic [FW-1:0]                    frame_cnt;
    logic [N_PADS-1:0][N_BITS-1:0]    shreg;
`ifdef T03_PAD_DEBOUNCE_EN
    logic [N_PADS-1:0][N_BITS-1:0]    hist;
`endif

    t03_pad_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk (clk),
        .nrst(nrst),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= StIdle;
            latch_cnt     <= '0;
            phase_cnt     <= '0;
            bit_cnt       <= '0;
            frame_cnt     <= '0;
            shreg         <= '0;
            pad_latch_o   <= 1'b0;
            pad_clk_o     <= 1'b0;
            buttons_o     <= '0;
            frame_valid_o <= 1'b0;
            busy_o        <= 1'b0;
`ifdef T03_PAD_DEBOUNCE_EN
            hist          <= '0;
`endif
        end else begin
            frame_valid_o <= 1'b0;
            // Saturates so short FRAME_TICKS cannot wrap during a long frame.
            if (tick && state != StIdle && frame_cnt != FrameMax) begin
                frame_cnt <= frame_cnt + FW'(1);
            end

            unique case (state)
                StIdle: begin
                    if (tick && (start_i || auto_i)) begin
                        state       <= StLatch;
                        frame_cnt   <= '0;
                        latch_cnt   <= '0;
                        pad_latch_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                StLatch: begin
                    if (tick) begin
                        if (latch_cnt == LatchLast) begin
                            state       <= StShift;
                            pad_latch_o <= 1'b0;
                            bit_cnt     <= '0;
                            phase_cnt   <= '0;
                        end else begin
                            latch_cnt <= latch_cnt + LW'(1);
                        end
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (phase_cnt == PhaseLast) begin
                            for (int p = 0; p < N_PADS; p++) begin
                                for (int i = 0; i < N_BITS; i++) begin
                                    if (bit_cnt == BW'(i)) shreg[p][i] <= ~pad_data_i[p];
                                end
                            end
                            phase_cnt <= '0;
                            if (bit_cnt == BitLast) begin
                                state     <= StDone;
                                pad_clk_o <= 1'b0;
                            end else begin
                                bit_cnt   <= bit_cnt + BW'(1);
                                pad_clk_o <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + PW'(1);
                            // Bit 0 is already on the line after latch; no clock edge.
                            pad_clk_o <= (bit_cnt != '0) && ((phase_cnt + PW'(1)) < PhaseHalf);
                        end
                    end
                end
                StDone: begin
`ifdef T03_PAD_DEBOUNCE_EN
                    buttons_o <= (buttons_o & ~(~(shreg ^ hist))) | (shreg & ~(shreg ^ hist));
                    hist      <= shreg;
`else
                    buttons_o <= shreg;
`endif
                    frame_valid_o <= 1'b1;
                    busy_o        <= 1'b0;
                    state         <= auto_i ? StWait : StIdle;
                end
                StWait: begin
                    if (tick) begin
                        if (!auto_i) begin
                            state <= StIdle;
                        end else if (frame_cnt >= FrameLast) begin
                            state       <= StLatch;
                            frame_cnt   <= '0;
                            latch_cnt   <= '0;
                            pad_latch_o <= 1'b1;
                            busy_o      <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_t03_pad_poll_engine.sv
// Scoreboard bench: two poller instances (8-bit/slow frame, 16-bit/back-to-back) with pad models.
module tb_t03_pad_poll_engine;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        a_start = 1'b0, a_auto = 1'b0;
    logic [1:0]  a_data;
    logic        a_latch, a_pclk, a_valid, a_busy;
    logic [15:0] a_btn;
    logic        b_start = 1'b0, b_auto = 1'b0;
    logic [1:0]  b_data;
    logic        b_latch, b_pclk, b_valid, b_busy;
    logic [31:0] b_btn;

    t03_pad_poll_engine #(
        .N_PADS(2), .N_BITS(8), .DIV(4), .LATCH_TICKS(30), .BIT_TICKS(30), .FRAME_TICKS(400)
    ) u_dut_a (
        .clk(clk), .nrst(nrst), .start_i(a_start), .auto_i(a_auto), .pad_data_i(a_data),
        .pad_latch_o(a_latch), .pad_clk_o(a_pclk), .buttons_o(a_btn),
        .frame_valid_o(a_valid), .busy_o(a_busy)
    );

    t03_pad_poll_engine #(
        .N_PADS(2), .N_BITS(16), .DIV(4), .LATCH_TICKS(30), .BIT_TICKS(30), .FRAME_TICKS(10)
    ) u_dut_b (
        .clk(clk), .nrst(nrst), .start_i(b_start), .auto_i(b_auto), .pad_data_i(b_data),
        .pad_latch_o(b_latch), .pad_clk_o(b_pclk), .buttons_o(b_btn),
        .frame_valid_o(b_valid), .busy_o(b_busy)
    );

    // Pad models: parallel load while latch high, shift on clock rise, active-low data.
    logic [7:0]  a_val [2];
    logic [7:0]  a_sr  [2];
    logic [15:0] b_val [2];
    logic [15:0] b_sr  [2];
    logic a_lat_q = 1'b0, a_pclk_q = 1'b0, b_lat_q = 1'b0, b_pclk_q = 1'b0;

    always @(posedge clk or negedge nrst) begin
        for (int p = 0; p < 2; p++) begin
            if (!nrst) begin
                a_sr[p] <= '0;
                b_sr[p] <= '0;
            end else begin
                if (a_latch) a_sr[p] <= a_val[p];
                else if (a_pclk && !a_pclk_q) a_sr[p] <= a_sr[p] >> 1;
                if (b_latch) b_sr[p] <= b_val[p];
                else if (b_pclk && !b_pclk_q) b_sr[p] <= b_sr[p] >> 1;
            end
        end
    end
    assign a_data = {~a_sr[1][0], ~a_sr[0][0]};
    assign b_data = {~b_sr[1][0], ~b_sr[0][0]};

    int cyc = 0;
    int a_lat_rises = 0, a_pclk_rises = 0, a_valids = 0, a_lat_rise_t = 0, a_lat_fall_t = 0;
    int a_valid_t = 0;
    int b_lat_rises = 0, b_pclk_rises = 0, b_valids = 0, b_lat_rise_t = 0, b_lat_fall_t = 0;
    int b_valid_t = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        a_lat_q <= a_latch;
        a_pclk_q <= a_pclk;
        b_lat_q <= b_latch;
        b_pclk_q <= b_pclk;
        if (a_latch && !a_lat_q) begin a_lat_rises <= a_lat_rises + 1; a_lat_rise_t <= cyc; end
        if (!a_latch && a_lat_q) a_lat_fall_t <= cyc;
        if (a_pclk && !a_pclk_q) a_pclk_rises <= a_pclk_rises + 1;
        if (a_valid) begin a_valids <= a_valids + 1; a_valid_t <= cyc; end
        if (b_latch && !b_lat_q) begin b_lat_rises <= b_lat_rises + 1; b_lat_rise_t <= cyc; end
        if (!b_latch && b_lat_q) b_lat_fall_t <= cyc;
        if (b_pclk && !b_pclk_q) b_pclk_rises <= b_pclk_rises + 1;
        if (b_valid) begin b_valids <= b_valids + 1; b_valid_t <= cyc; end
    end

    // Expected-value model and scoreboard queues.
    logic [15:0] a_q[$];
    logic [31:0] b_q[$];
    logic [15:0] a_mbtn = '0, a_mhist = '0;
    logic [31:0] b_mbtn = '0, b_mhist = '0;

    function automatic logic [31:0] deb_next(input logic [31:0] smp, input logic [31:0] btn,
                                             input logic [31:0] hist);
        logic [31:0] agree;
`ifdef T03_PAD_DEBOUNCE_EN
        agree = ~(smp ^ hist);
`else
        agree = '1;
`endif
        return (btn & ~agree) | (smp & agree);
    endfunction

    task automatic push_a(input logic [7:0] v0, input logic [7:0] v1);
        a_val[0] = v0;
        a_val[1] = v1;
        a_mbtn = 16'(deb_next({16'h0, v1, v0}, {16'h0, a_mbtn}, {16'h0, a_mhist}));
        a_mhist = {v1, v0};
        a_q.push_back(a_mbtn);
    endtask

    task automatic push_b(input logic [15:0] v0, input logic [15:0] v1);
        b_val[0] = v0;
        b_val[1] = v1;
        b_mbtn = deb_next({v1, v0}, b_mbtn, b_mhist);
        b_mhist = {v1, v0};
        b_q.push_back(b_mbtn);
    endtask

    task automatic start_a();
        @(negedge clk);
        a_start = 1'b1;
        for (int i = 0; i < 20 && a_busy !== 1'b1; i++) @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic start_b();
        @(negedge clk);
        b_start = 1'b1;
        for (int i = 0; i < 20 && b_busy !== 1'b1; i++) @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_a_valid(input int budget);
        for (int i = 0; i < budget && a_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_b_valid(input int budget);
        for (int i = 0; i < budget && b_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_latch, a_pclk, a_valid, a_busy} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_a_ctrl: got %b want 0000", {a_latch, a_pclk, a_valid, a_busy});
        end
        n_cmp++;
        if (a_btn !== 16'h0) begin n_bad++; $display("FAIL reset_a_btn: got %h want 0", a_btn); end
        n_cmp++;
        if ({b_latch, b_pclk, b_valid, b_busy, b_btn} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_b: got %h want 0", {b_latch, b_pclk, b_valid, b_busy, b_btn});
        end
        nrst = 1'b1;
        repeat (60) @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b0 || a_lat_rises != 0 || b_lat_rises != 0) begin
            n_bad++;
            $display("FAIL idle_no_start: got busy=%b rises=%0d/%0d want 0", a_busy, a_lat_rises,
                     b_lat_rises);
        end
    endtask

    task automatic test_one_shot();
        int v0, p0;
        logic [15:0] exp;
        push_a(8'h5A, 8'h00);
        v0 = a_valids;
        p0 = a_pclk_rises;
        start_a();
        wait_a_valid(3000);
        n_cmp++;
        if (a_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL one_shot_valid: got %b want 1", a_valid);
        end else begin
            exp = a_q.pop_front();
            n_cmp++;
            if (a_btn !== exp) begin n_bad++; $display("FAIL one_shot_btn: got %h want %h", a_btn, exp); end
        end
        @(negedge clk);
        n_cmp++;
        if (a_lat_fall_t - a_lat_rise_t != 120) begin
            n_bad++;
            $display("FAIL latch_width: got %0d want 120", a_lat_fall_t - a_lat_rise_t);
        end
        n_cmp++;
        if (a_pclk_rises - p0 != 7) begin
            n_bad++;
            $display("FAIL pclk_rises_8: got %0d want 7", a_pclk_rises - p0);
        end
        // Latch 30 ticks + 8 bits x 30 ticks, valid registered one clock after DONE.
        n_cmp++;
        if (a_valid_t - a_lat_rise_t != 1081) begin
            n_bad++;
            $display("FAIL valid_latency: got %0d want 1081", a_valid_t - a_lat_rise_t);
        end
        n_cmp++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_done: got valid=%b busy=%b want 0 0", a_valid, a_busy);
        end
        repeat (50) @(negedge clk);
        n_cmp++;
        if (a_valids - v0 != 1) begin
            n_bad++;
            $display("FAIL one_shot_count: got %0d want 1", a_valids - v0);
        end
    endtask

    task automatic test_two_pads_16();
        int p0;
        logic [31:0] exp;
        push_b(16'h0081, 16'h003C);
        p0 = b_pclk_rises;
        start_b();
        wait_b_valid(4000);
        n_cmp++;
        if (b_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL snes_valid: got %b want 1", b_valid);
        end else begin
            exp = b_q.pop_front();
            n_cmp++;
            if (b_btn !== exp) begin n_bad++; $display("FAIL snes_btn: got %h want %h", b_btn, exp); end
        end
        @(negedge clk);
        n_cmp++;
        if (b_pclk_rises - p0 != 15) begin
            n_bad++;
            $display("FAIL pclk_rises_16: got %0d want 15", b_pclk_rises - p0);
        end
        n_cmp++;
        if (b_valid_t - b_lat_rise_t != 2041) begin
            n_bad++;
            $display("FAIL snes_latency: got %0d want 2041", b_valid_t - b_lat_rise_t);
        end
    endtask

    task automatic test_start_ignored();
        int v0, l0;
        logic [15:0] exp;
        push_a(8'hFF, 8'h11);
        v0 = a_valids;
        l0 = a_lat_rises;
        start_a();
        for (int i = 0; i < 1000 && a_pclk !== 1'b1; i++) @(negedge clk);
        a_start = 1'b1;
        repeat (10) @(negedge clk);
        a_start = 1'b0;
        wait_a_valid(3000);
        n_cmp++;
        if (a_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ignored_valid: got %b want 1", a_valid);
        end else begin
            exp = a_q.pop_front();
            n_cmp++;
            if (a_btn !== exp) begin n_bad++; $display("FAIL ignored_btn: got %h want %h", a_btn, exp); end
        end
        repeat (400) @(negedge clk);
        n_cmp++;
        if (a_valids - v0 != 1 || a_lat_rises - l0 != 1 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_ignored: got valids=%0d latches=%0d busy=%b want 1 1 0",
                     a_valids - v0, a_lat_rises - l0, a_busy);
        end
    endtask

    task automatic test_auto();
        int v0, l0, t1;
        logic [15:0] exp;
        v0 = a_valids;
        l0 = a_lat_rises;
        push_a(8'h01, 8'h80);
        @(negedge clk);
        a_auto = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                for (int i = 0; i < 3000 && a_pclk !== 1'b1; i++) @(negedge clk);
                a_auto = 1'b0;
            end
            wait_a_valid(3000);
            n_cmp++;
            if (a_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL auto_valid_%0d: got %b want 1", f, a_valid);
            end else begin
                exp = a_q.pop_front();
                n_cmp++;
                if (a_btn !== exp) begin
                    n_bad++;
                    $display("FAIL auto_btn_%0d: got %h want %h", f, a_btn, exp);
                end
            end
            if (f == 0) begin
                t1 = a_lat_rise_t;
                push_a(8'hC3, 8'h24);
            end else if (f == 1) begin
                n_cmp++;
                if (a_lat_rise_t - t1 != 1600) begin
                    n_bad++;
                    $display("FAIL auto_period: got %0d want 1600", a_lat_rise_t - t1);
                end
                push_a(8'h7E, 8'h00);
            end
            @(negedge clk);
        end
        repeat (2500) @(negedge clk);
        n_cmp++;
        if (a_lat_rises - l0 != 3 || a_valids - v0 != 3 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_drop: got latches=%0d valids=%0d busy=%b want 3 3 0",
                     a_lat_rises - l0, a_valids - v0, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        int l0, t1;
        logic [31:0] exp;
        l0 = b_lat_rises;
        push_b(16'hA5A5, 16'h0F0F);
        @(negedge clk);
        b_auto = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_b_valid(4000);
            n_cmp++;
            if (b_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_valid_%0d: got %b want 1", f, b_valid);
            end else begin
                exp = b_q.pop_front();
                n_cmp++;
                if (b_btn !== exp) begin
                    n_bad++;
                    $display("FAIL b2b_btn_%0d: got %h want %h", f, b_btn, exp);
                end
            end
            if (f == 0) begin
                t1 = b_lat_rise_t;
                push_b(16'h1234, 16'h8001);
                @(negedge clk);
            end else begin
                b_auto = 1'b0;  // FSM now in WAIT
            end
        end
        // 510-tick frame, DONE, then WAIT leaves on the next tick: 511 ticks.
        n_cmp++;
        if (b_lat_rise_t - t1 != 2044) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d want 2044", b_lat_rise_t - t1);
        end
        repeat (300) @(negedge clk);
        n_cmp++;
        if (b_lat_rises - l0 != 2 || b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_to_idle: got latches=%0d busy=%b want 2 0", b_lat_rises - l0, b_busy);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] vals [5];
        logic [4:0] want_b3;
        logic [15:0] exp;
        vals = '{8'h00, 8'h08, 8'h00, 8'h08, 8'h08};
`ifdef T03_PAD_DEBOUNCE_EN
        want_b3 = 5'b10000;
`else
        want_b3 = 5'b11010;
`endif
        for (int k = 0; k < 5; k++) begin
            push_a(vals[k], 8'h00);
            start_a();
            wait_a_valid(3000);
            n_cmp++;
            if (a_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL deb_valid_%0d: got %b want 1", k, a_valid);
            end else begin
                exp = a_q.pop_front();
                n_cmp++;
                if (a_btn !== exp) begin
                    n_bad++;
                    $display("FAIL deb_btn_%0d: got %h want %h", k, a_btn, exp);
                end
                n_cmp++;
                if (a_btn[3] !== want_b3[k]) begin
                    n_bad++;
                    $display("FAIL deb_bit3_%0d: got %b want %b", k, a_btn[3], want_b3[k]);
                end
            end
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, l0;
        start_a();
        for (int i = 0; i < 1000 && a_pclk !== 1'b1; i++) @(negedge clk);
        n_cmp++;
        if (a_pclk !== 1'b1) begin n_bad++; $display("FAIL mid_shift_reach: got %b want 1", a_pclk); end
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({a_latch, a_pclk, a_valid, a_busy, a_btn} !== 20'h0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h want 0", {a_latch, a_pclk, a_valid, a_busy, a_btn});
        end
        v0 = a_valids;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        a_mbtn = '0;
        a_mhist = '0;
        a_q.delete();
        l0 = a_lat_rises;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (a_valids != v0 || a_lat_rises != l0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got valids=%0d latches=%0d busy=%b want %0d %0d 0",
                     a_valids, a_lat_rises, a_busy, v0, l0);
        end
    endtask

    initial begin
        a_val[0] = '0; a_val[1] = '0;
        b_val[0] = '0; b_val[1] = '0;
        test_reset();
        test_one_shot();
        test_two_pads_16();
        test_start_ignored();
        test_auto();
        test_back_to_back();
        test_debounce();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
